imem_fetch_responder: RTL and testbench

- Responder side of the instruction-fetch interface: a word-organised instruction memory that answers fetch requests after a fixed, parameterised latency, through a valid/ready handshake.
- Includes a program-loader write port used by benches and boot logic to fill memory.
- Supports flush (taken branch) to discard an in-flight fetch.
- Sits between the fetch stage (the initiator) and the loader. It replaces the zero-latency combinational lookup with a timed responder.

---
 rtl/imem_fetch_responder.sv | 109 ++++++++++
 tb/tb_imem_fetch_responder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_responder.sv
// Word-organised instruction memory answering fetch requests after a fixed latency,
// with a loader write port and flush support for taken branches.
module imem_fetch_responder #(
    parameter int          DEPTH    = 64,
    parameter int          LATENCY  = 2,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [63:0] req_addr,
    output logic        req_ready,
    input  logic        flush,
    output logic        resp_valid,
    output logic [31:0] resp_inst,
    output logic        resp_fault,
    input  logic        load_en,
    input  logic [63:0] load_addr,
    input  logic [31:0] load_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  countdown, countdown_nxt;
    logic [63:0] lat_addr;
    logic [31:0] mem [DEPTH];
    logic        accept;
    logic        lat_fault;
    logic        load_ok;

    assign req_ready = ((state == IDLE) || (state == RESP)) && !load_en && !flush;
    assign accept    = req_valid && req_ready;
    assign lat_fault = (lat_addr[1:0] != 2'b00) || (lat_addr[63:2] >= 62'(DEPTH));
    assign load_ok   = load_en && (load_addr[1:0] == 2'b00) && (load_addr[63:2] < 62'(DEPTH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            countdown <= 4'd0;
            lat_addr  <= 64'd0;
        end else begin
            state     <= state_nxt;
            countdown <= countdown_nxt;
            if (accept) begin
                lat_addr <= req_addr;
            end
        end
    end

    // Memory is deliberately left out of reset so a reset keeps the loaded program.
    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem[load_addr[AW+1:2]] <= load_data;
        end
    end

    always_comb begin
        state_nxt     = state;
        countdown_nxt = countdown;
        resp_valid    = 1'b0;
        resp_inst     = 32'd0;
        resp_fault    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    countdown_nxt = 4'(LATENCY - 1);
                    state_nxt     = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else begin
                    countdown_nxt = countdown - 4'd1;
                    if (countdown == 4'd1) begin
                        state_nxt = RESP;
                    end
                end
            end
            RESP: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else begin
                    resp_valid = 1'b1;
                    resp_inst  = lat_fault ? NOP_INST : mem[lat_addr[AW+1:2]];
                    resp_fault = lat_fault;
                    // A fetch accepted in the response cycle restarts the timer for back-to-back throughput.
                    if (accept) begin
                        countdown_nxt = 4'(LATENCY - 1);
                        state_nxt     = (LATENCY == 1) ? RESP : WAIT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Scoreboard bench for imem_fetch_responder: stimulus pushes expected responses,
// a negedge monitor pops and compares them against every resp_valid pulse.
module tb_imem_fetch_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [63:0] req_addr = 64'd0;
    logic        req_ready;
    logic        flush = 1'b0;
    logic        resp_valid;
    logic [31:0] resp_inst;
    logic        resp_fault;
    logic        load_en = 1'b0;
    logic [63:0] load_addr = 64'd0;
    logic [31:0] load_data = 32'd0;

    typedef struct {
        logic [31:0] inst;
        logic        fault;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    imem_fetch_responder #(.DEPTH(64), .LATENCY(LAT), .NOP_INST(32'h00000013)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_inst  (resp_inst),
        .resp_fault (resp_fault),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every cycle a response is either expected from the queue or must be all zero.
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_resp: got resp_inst %0h at cycle %0d, required no response", resp_inst, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("resp_cycle", 64'(cyc), 64'(e.cyc));
                chk("resp_inst", 64'(resp_inst), 64'(e.inst));
                chk("resp_fault", 64'(resp_fault), 64'(e.fault));
            end
        end else begin
            chk("idle_outputs", {31'd0, resp_fault, resp_inst}, 64'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [63:0] addr, input logic [31:0] data);
        load_en   = 1'b1;
        load_addr = addr;
        load_data = data;
        @(negedge clk);
        chk("ready_during_load", 64'(req_ready), 64'd0);
        tick();
        load_en = 1'b0;
    endtask

    // Holds the request until accepted; returns the cycle in which it was accepted.
    task automatic fetch(input logic [63:0] addr, input logic [31:0] inst, input logic fault,
                         input bit push, output int acc);
        bit done;
        done      = 0;
        acc       = -1;
        req_valid = 1'b1;
        req_addr  = addr;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (req_ready === 1'b1) begin
                acc  = cyc;
                done = 1;
                if (push) q.push_back('{inst: inst, fault: fault, cyc: cyc + LAT});
            end
            tick();
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: addr %0h never accepted, required acceptance", addr);
        end
        req_valid = 1'b0;
    endtask

    initial begin
        int a, b;
        #2;
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_inst", 64'(resp_inst), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        tick();
        reset = 1'b0;
        tick();

        do_load(64'h0, 32'h00A00093);
        do_load(64'h4, 32'h00108113);
        do_load(64'h8, 32'h00208193);

        // Basic fetch
        fetch(64'h4, 32'h00108113, 1'b0, 1, a);
        repeat (3) tick();

        // Back-to-back: second accept lands in the first response cycle
        fetch(64'h0, 32'h00A00093, 1'b0, 1, a);
        fetch(64'h4, 32'h00108113, 1'b0, 1, b);
        chk("b2b_accept_gap", 64'(b - a), 64'(LAT));
        repeat (3) tick();

        // Faults
        fetch(64'h2, 32'h00000013, 1'b1, 1, a);
        fetch(64'h100, 32'h00000013, 1'b1, 1, a);
        repeat (3) tick();

        // Dropped loads must not alias onto word 0
        do_load(64'h100, 32'hFFFFFFFF);
        do_load(64'h2, 32'hFFFFFFFF);
        fetch(64'h0, 32'h00A00093, 1'b0, 1, a);
        repeat (3) tick();

        // Flush in WAIT
        fetch(64'h0, 32'h0, 1'b0, 0, a);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_wait_ready", 64'(req_ready), 64'd0);
        chk("flush_wait_valid", 64'(resp_valid), 64'd0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("after_flush_ready", 64'(req_ready), 64'd1);
        tick();
        fetch(64'h8, 32'h00208193, 1'b0, 1, a);
        repeat (3) tick();

        // Flush in RESP
        fetch(64'h4, 32'h0, 1'b0, 0, a);
        tick();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_resp_valid", 64'(resp_valid), 64'd0);
        chk("flush_resp_inst", 64'(resp_inst), 64'd0);
        tick();
        flush = 1'b0;
        repeat (2) tick();

        // Load during WAIT is visible in the response
        fetch(64'h8, 32'hDEADBEEF, 1'b0, 1, a);
        do_load(64'h8, 32'hDEADBEEF);
        repeat (3) tick();

        // Load at the RESP edge is not visible in that response, only in the next fetch
        fetch(64'h0, 32'h00A00093, 1'b0, 1, a);
        tick();
        do_load(64'h0, 32'h11111111);
        repeat (2) tick();
        fetch(64'h0, 32'h11111111, 1'b0, 1, a);
        repeat (3) tick();

        // Asynchronous reset in WAIT abandons the fetch
        fetch(64'h4, 32'h0, 1'b0, 0, a);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_ready", 64'(req_ready), 64'd1);
        chk("async_rst_valid", 64'(resp_valid), 64'd0);
        chk("async_rst_inst", 64'(resp_inst), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        repeat (3) tick();
        fetch(64'h4, 32'h00108113, 1'b0, 1, a);

        for (int i = 0; i < 50 && q.size() != 0; i++) tick();
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missing_resp: %0d responses outstanding, required 0", q.size());
        end
        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

endmodule
